wrr_arbiter: RTL and testbench
==============================

WRR_ARBITER -- requirements
Module: wrr_arbiter

Interface
REQ-001 SHALL have parameter NumIn, default 4, number of requesting channels (2..64).
REQ-002 SHALL have parameter DataWidth, default 32, payload width per channel.
REQ-003 SHALL have parameter WeightWidth, default 4, width of each per-channel weight.
REQ-004 SHALL have parameter OutReg, default 1'b0; 0 = combinational output path, 1 = one registered output stage.
REQ-005 SHALL have port clk_i, input, 1, clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port flush_i, input, 1, synchronous return of all state to reset values.
REQ-008 SHALL have port weight_i, input, NumIn x WeightWidth, packets per turn for each channel.
REQ-009 SHALL have port req_i, input, NumIn, per-channel valid.
REQ-010 SHALL have port data_i, input, NumIn x DataWidth, per-channel payload.
REQ-011 SHALL have port last_i, input, NumIn, per-channel end-of-packet marker.
REQ-012 SHALL have port gnt_o, output, NumIn, per-channel ready; one-hot or zero.
REQ-013 SHALL have port req_o, input/output naming aside, output, 1, downstream valid.
REQ-014 SHALL have port gnt_i, input, 1, downstream ready.
REQ-015 SHALL have ports data_o (DataWidth), last_o (1) and idx_o ($clog2(NumIn)), all outputs, giving the payload, end-of-packet marker and source channel of the current beat.

Function
REQ-016 SHALL count a beat as transferred on channel k when req_i[k] & gnt_o[k] in the same cycle.
REQ-017 SHALL hold FSM state IDLE (no owner), OWN (owner at a packet boundary) or PKT (owner mid-packet), plus owner index, round-robin pointer ptr and credit counter.
REQ-018 SHALL, in IDLE or on rotation, select the first requesting channel, searching circularly from ptr+1 mod NumIn, load credit = weight_i[sel], and treat a weight of 0 as 1.
REQ-019 SHALL present only the owner channel downstream: req_o = req_i[owner], and data_o, last_o and idx_o taken from the owner channel.
REQ-020 SHALL let the IDLE-cycle selection be combinationally visible, so the first beat can transfer in the selection cycle (zero-cycle arbitration latency).
REQ-021 SHALL, on a transfer with last=0, enter or stay in PKT; in PKT the owner is locked regardless of other requests and of req_i[owner] dropping.
REQ-022 SHALL, on a transfer with last=1, decrement credit; if credit becomes 0, set ptr = owner and re-arbitrate in the next cycle; otherwise go to OWN.
REQ-023 SHALL, in OWN with req_i[owner]=0 and at least one other channel requesting, set ptr = owner and re-arbitrate; with no channel requesting, go to IDLE keeping ptr = owner.
REQ-024 SHALL keep owner, credit and state unchanged while req_o & ~gnt_i; a transfer stalled by backpressure never changes arbitration.
REQ-025 SHALL, when only one channel requests, keep granting it indefinitely by reloading its credit on each rotation.
REQ-026 SHALL, with OutReg=1, insert one register stage: gnt_o[owner] = ~out_valid_q | gnt_i; full throughput; req_o, data_o, last_o and idx_o driven from the register; beats are never dropped or duplicated.
REQ-027 SHALL hold credit at WeightWidth bits and never let it wrap below 0.

Reset
REQ-028 SHALL, on rst_ni low or flush_i high, set state = IDLE, ptr = NumIn-1 (channel 0 wins first), credit = 0, owner = 0 and the output register empty.
REQ-029 SHALL drive req_o = 0, gnt_o = 0, last_o = 0, idx_o = 0 and data_o = 0 during reset.
REQ-030 SHALL, on flush mid-packet, abandon the packet; in the cycle after flush the arbiter behaves as IDLE from reset.

Verification
REQ-031 SHALL verify: NumIn=4, weights all 1, req_i=4'b1111, single-beat packets, gnt_i=1 -> idx_o sequence 0,1,2,3,0,...
REQ-032 SHALL verify: weights {3,1,1,1}, all requesting, single-beat packets -> idx_o sequence 0,0,0,1,2,3,0,0,0.
REQ-033 SHALL verify: channel 1 sends a 4-beat packet while channel 0 requests continuously -> idx_o = 1 for all 4 beats; channel 0 is granted only after last_i[1]=1 transfers.
REQ-034 SHALL verify: gnt_i held 0 for 5 cycles mid-packet -> req_o, idx_o and data_o stay stable; credit and owner unchanged.
REQ-035 SHALL verify: flush_i pulsed on beat 2 of a 4-beat packet -> next cycle req_o=0 and gnt_o=0; with req_i=4'b1111, the next grant goes to channel 0.
REQ-036 SHALL verify: OutReg=1, all channels streaming, gnt_i=1 -> one beat per cycle after 1-cycle latency; under random gnt_i the beat order matches OutReg=0 with no loss.

Source files
------------

// File: rtl/wrr_arbiter.sv
// Weighted round-robin packet arbiter: NumIn upstream channels share one downstream port.
// Each winner keeps the port for weight packets; the owner stays locked mid-packet.
module wrr_arbiter #(
  parameter int unsigned NumIn       = 4,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned WeightWidth = 4,
  parameter bit          OutReg      = 1'b0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  flush_i,
  input  logic [NumIn-1:0][WeightWidth-1:0]     weight_i,
  input  logic [NumIn-1:0]                      req_i,
  input  logic [NumIn-1:0][DataWidth-1:0]       data_i,
  input  logic [NumIn-1:0]                      last_i,
  output logic [NumIn-1:0]                      gnt_o,
  output logic                                  req_o,
  input  logic                                  gnt_i,
  output logic [DataWidth-1:0]                  data_o,
  output logic                                  last_o,
  output logic [$clog2(NumIn)-1:0]              idx_o
);

  localparam int unsigned IdxW = $clog2(NumIn);

  typedef enum logic [1:0] {IDLE, OWN, PKT} state_e;

  state_e                 state_q;
  logic [IdxW-1:0]        owner_q, ptr_q;
  logic [WeightWidth-1:0] credit_q;

  logic                   any_req;
  logic [IdxW-1:0]        sel, cur_owner;
  logic [WeightWidth-1:0] sel_credit, cur_credit, credit_dec;
  logic                   active, up_valid, up_ready, xfer;

  // Circular search starting just after the last owner.
  always_comb begin
    int c;
    c       = 0;
    any_req = 1'b0;
    sel     = '0;
    for (int i = 1; i <= int'(NumIn); i++) begin
      c = (int'(ptr_q) + i) % int'(NumIn);
      if (!any_req && req_i[c]) begin
        any_req = 1'b1;
        sel     = IdxW'(c);
      end
    end
  end

  assign sel_credit = (weight_i[sel] == '0) ? WeightWidth'(1) : weight_i[sel];

  // In IDLE the fresh selection acts as owner in the same cycle.
  assign cur_owner  = (state_q == IDLE) ? sel : owner_q;
  assign cur_credit = (state_q == IDLE) ? sel_credit : credit_q;
  assign credit_dec = (cur_credit == '0) ? '0 : cur_credit - WeightWidth'(1);

  assign active   = rst_ni & ~flush_i & ((state_q != IDLE) | any_req);
  assign up_valid = active & req_i[cur_owner];
  assign xfer     = up_valid & up_ready;

  always_comb begin
    gnt_o = '0;
    if (active && up_ready) gnt_o[cur_owner] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      ptr_q    <= IdxW'(NumIn - 1);
      credit_q <= '0;
    end else if (flush_i) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      ptr_q    <= IdxW'(NumIn - 1);
      credit_q <= '0;
    end else if (xfer) begin
      owner_q <= cur_owner;
      if (!last_i[cur_owner]) begin
        state_q  <= PKT;
        credit_q <= cur_credit;
      end else if (credit_dec == '0) begin
        state_q  <= IDLE;
        ptr_q    <= cur_owner;
        credit_q <= '0;
      end else begin
        state_q  <= OWN;
        credit_q <= credit_dec;
      end
    end else if (state_q == OWN && !req_i[owner_q]) begin
      // Owner went quiet between packets: give the turn away.
      state_q  <= IDLE;
      ptr_q    <= owner_q;
      credit_q <= '0;
    end
  end

  if (OutReg) begin : g_out_reg
    logic                 ov_q, last_q;
    logic [DataWidth-1:0] data_q;
    logic [IdxW-1:0]      idx_q;

    assign up_ready = ~ov_q | gnt_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        ov_q   <= 1'b0;
        last_q <= 1'b0;
        data_q <= '0;
        idx_q  <= '0;
      end else if (flush_i) begin
        ov_q   <= 1'b0;
        last_q <= 1'b0;
        data_q <= '0;
        idx_q  <= '0;
      end else if (up_ready) begin
        ov_q <= up_valid;
        if (up_valid) begin
          last_q <= last_i[cur_owner];
          data_q <= data_i[cur_owner];
          idx_q  <= cur_owner;
        end
      end
    end

    assign req_o  = ov_q;
    assign data_o = data_q;
    assign last_o = last_q;
    assign idx_o  = idx_q;
  end else begin : g_out_comb
    assign up_ready = gnt_i;
    assign req_o    = up_valid;
    assign data_o   = rst_ni ? data_i[cur_owner] : '0;
    assign last_o   = rst_ni & last_i[cur_owner];
    assign idx_o    = rst_ni ? cur_owner : '0;
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: directed scenarios plus random streams checked against
// a packet-level round-robin model, for both output-path variants.
module tb_wrr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int WW  = 4;
  localparam int NPK = 128;

  typedef struct {
    logic [1:0]    idx;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_d = 1'b0;
  logic mode = 1'b0;
  logic [N-1:0][WW-1:0] weight_d = '0;
  logic [N-1:0]         req_d = '0, last_d = '0;
  logic [N-1:0][DW-1:0] data_d = '0;
  logic                 gnt_d = 1'b0;

  logic [N-1:0]  req_a, req_b, gnt_a, gnt_b;
  logic          ro_a, ro_b, lo_a, lo_b;
  logic [DW-1:0] do_a, do_b;
  logic [1:0]    io_a, io_b;

  logic [N-1:0]  so_gnt;
  logic          so_req, so_last;
  logic [DW-1:0] so_data;
  logic [1:0]    so_idx;

  int checks = 0;
  int errors = 0;
  int wt[N];

  assign req_a = mode ? '0 : req_d;
  assign req_b = mode ? req_d : '0;
  assign so_gnt  = mode ? gnt_b : gnt_a;
  assign so_req  = mode ? ro_b : ro_a;
  assign so_last = mode ? lo_b : lo_a;
  assign so_data = mode ? do_b : do_a;
  assign so_idx  = mode ? io_b : io_a;

  wrr_arbiter #(.NumIn(N), .DataWidth(DW), .WeightWidth(WW), .OutReg(1'b0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_d), .weight_i(weight_d),
    .req_i(req_a), .data_i(data_d), .last_i(last_d), .gnt_o(gnt_a),
    .req_o(ro_a), .gnt_i(gnt_d), .data_o(do_a), .last_o(lo_a), .idx_o(io_a));

  wrr_arbiter #(.NumIn(N), .DataWidth(DW), .WeightWidth(WW), .OutReg(1'b1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_d), .weight_i(weight_d),
    .req_i(req_b), .data_i(data_d), .last_i(last_d), .gnt_o(gnt_b),
    .req_o(ro_b), .gnt_i(gnt_d), .data_o(do_b), .last_o(lo_b), .idx_o(io_b));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_weights();
    for (int k = 0; k < N; k++) weight_d[k] = WW'(wt[k]);
  endtask

  task automatic flush_pulse(input logic m);
    mode    = m;
    flush_d = 1'b1;
    req_d   = '0;
    last_d  = '0;
    gnt_d   = 1'b1;
    tick();
    flush_d = 1'b0;
  endtask

  // Drive one cycle of inputs, then let outputs settle mid-cycle.
  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic g);
    req_d  = r;
    last_d = l;
    gnt_d  = g;
    #4;
  endtask

  task automatic test_reset();
    req_d  = '1;
    last_d = '1;
    gnt_d  = 1'b1;
    for (int k = 0; k < N; k++) data_d[k] = $urandom | 32'h1;
    tick(); tick();
    #4;
    checks++; if (ro_a !== 1'b0) begin errors++; $display("FAIL reset_req_a got %b want 0", ro_a); end
    checks++; if (gnt_a !== 4'b0) begin errors++; $display("FAIL reset_gnt_a got %b want 0000", gnt_a); end
    checks++; if (do_a !== '0) begin errors++; $display("FAIL reset_data_a got %h want 0", do_a); end
    checks++; if (lo_a !== 1'b0) begin errors++; $display("FAIL reset_last_a got %b want 0", lo_a); end
    checks++; if (io_a !== 2'd0) begin errors++; $display("FAIL reset_idx_a got %0d want 0", io_a); end
    checks++; if (ro_b !== 1'b0) begin errors++; $display("FAIL reset_req_b got %b want 0", ro_b); end
    checks++; if (gnt_b !== 4'b0) begin errors++; $display("FAIL reset_gnt_b got %b want 0000", gnt_b); end
    checks++; if (do_b !== '0) begin errors++; $display("FAIL reset_data_b got %h want 0", do_b); end
    req_d  = '0;
    last_d = '0;
    rst_n  = 1'b1;
    tick();
  endtask

  // All channels permanently backlogged: the model hands out turns 0,1,2,3,...
  // each worth max(weight,1) whole packets, independent of backpressure timing.
  task automatic run_stream(input logic m, input int nb, input int maxlen, input int gpct,
                            input string nm);
    int    plen[N][NPK];
    int    pk[N];
    int    bt[N];
    int    mp[N];
    beat_t exp_q[$];
    beat_t e;
    int    obs, cyc, ch, w;
    set_weights();
    flush_pulse(m);
    for (int k = 0; k < N; k++) begin
      pk[k] = 0; bt[k] = 0; mp[k] = 0;
      for (int p = 0; p < NPK; p++) plen[k][p] = $urandom_range(maxlen, 1);
    end
    ch = 0;
    while (exp_q.size() < nb) begin
      w = (wt[ch] == 0) ? 1 : wt[ch];
      for (int p = 0; p < w; p++) begin
        for (int b = 0; b < plen[ch][mp[ch]]; b++) begin
          e.idx  = 2'(ch);
          e.data = {8'(ch), 12'(mp[ch]), 12'(b)};
          e.last = (b == plen[ch][mp[ch]] - 1);
          exp_q.push_back(e);
        end
        mp[ch]++;
      end
      ch = (ch + 1) % N;
    end
    obs = 0;
    cyc = 0;
    while (obs < nb && cyc < 3000) begin
      for (int k = 0; k < N; k++) begin
        data_d[k] = {8'(k), 12'(pk[k]), 12'(bt[k])};
        last_d[k] = (bt[k] == plen[k][pk[k]] - 1);
      end
      req_d = '1;
      gnt_d = ($urandom_range(99) < gpct);
      #4;
      checks++;
      if (!$onehot0(so_gnt)) begin
        errors++; $display("FAIL %s gnt_onehot cycle %0d got %b want one-hot or zero", nm, cyc, so_gnt);
      end
      if (so_req && gnt_d) begin
        e = exp_q[obs];
        checks++;
        if (so_idx !== e.idx || so_data !== e.data || so_last !== e.last) begin
          errors++;
          $display("FAIL %s beat %0d got idx %0d data %h last %b want idx %0d data %h last %b",
                   nm, obs, so_idx, so_data, so_last, e.idx, e.data, e.last);
        end
        obs++;
      end
      for (int k = 0; k < N; k++) begin
        if (so_gnt[k]) begin
          if (last_d[k]) begin pk[k]++; bt[k] = 0; end
          else bt[k]++;
        end
      end
      cyc++;
      tick();
    end
    checks++;
    if (obs != nb) begin errors++; $display("FAIL %s beats got %0d want %0d (cycle budget)", nm, obs, nb); end
    if (gpct == 100) begin
      checks++;
      if (cyc != nb + int'(m)) begin
        errors++; $display("FAIL %s throughput cycles got %0d want %0d", nm, cyc, nb + int'(m));
      end
    end
    req_d  = '0;
    last_d = '0;
  endtask

  task automatic test_round_robin();
    wt = '{1, 1, 1, 1};
    run_stream(1'b0, 12, 1, 100, "round_robin");
  endtask

  task automatic test_weighted();
    wt = '{3, 1, 1, 1};
    run_stream(1'b0, 12, 1, 100, "weighted");
  endtask

  task automatic test_random();
    for (int k = 0; k < N; k++) wt[k] = $urandom_range(3, 0);
    run_stream(1'b0, 100, 4, 60, "random_comb");
    run_stream(1'b1, 100, 4, 60, "random_reg");
  endtask

  task automatic test_out_reg();
    for (int k = 0; k < N; k++) wt[k] = $urandom_range(3, 1);
    run_stream(1'b1, 60, 4, 100, "outreg_stream");
  endtask

  task automatic test_packet_lock();
    wt = '{1, 1, 1, 1};
    set_weights();
    flush_pulse(1'b0);
    for (int k = 0; k < N; k++) data_d[k] = {8'(k), 24'h0};
    for (int b = 0; b < 4; b++) begin
      data_d[1] = 32'h100 + 32'(b);
      drive((b == 0) ? 4'b0010 : 4'b0011, (b == 3) ? 4'b0010 : 4'b0000, 1'b1);
      checks++; if (so_idx !== 2'd1) begin errors++; $display("FAIL lock_idx beat %0d got %0d want 1", b, so_idx); end
      checks++; if (so_gnt !== 4'b0010) begin errors++; $display("FAIL lock_gnt beat %0d got %b want 0010", b, so_gnt); end
      checks++; if (so_data !== 32'h100 + 32'(b)) begin errors++; $display("FAIL lock_data beat %0d got %h want %h", b, so_data, 32'h100 + 32'(b)); end
      tick();
    end
    drive(4'b0001, 4'b0001, 1'b1);
    checks++; if (so_idx !== 2'd0) begin errors++; $display("FAIL lock_next_idx got %0d want 0", so_idx); end
    checks++; if (so_gnt !== 4'b0001) begin errors++; $display("FAIL lock_next_gnt got %b want 0001", so_gnt); end
    tick();
  endtask

  task automatic test_backpressure();
    wt = '{1, 1, 2, 1};
    set_weights();
    flush_pulse(1'b0);
    data_d[2] = 32'h200;
    drive(4'b0100, 4'b0000, 1'b1);
    checks++; if (so_idx !== 2'd2) begin errors++; $display("FAIL bp_first_idx got %0d want 2", so_idx); end
    tick();
    data_d[2] = 32'h201;
    for (int c = 0; c < 5; c++) begin
      drive(4'b1111, 4'b0000, 1'b0);
      checks++; if (so_req !== 1'b1) begin errors++; $display("FAIL bp_req cycle %0d got %b want 1", c, so_req); end
      checks++; if (so_idx !== 2'd2) begin errors++; $display("FAIL bp_idx cycle %0d got %0d want 2", c, so_idx); end
      checks++; if (so_data !== 32'h201) begin errors++; $display("FAIL bp_data cycle %0d got %h want 201", c, so_data); end
      checks++; if (so_gnt !== 4'b0000) begin errors++; $display("FAIL bp_gnt cycle %0d got %b want 0000", c, so_gnt); end
      tick();
    end
    for (int b = 1; b < 5; b++) begin
      data_d[2] = 32'h200 + 32'(b);
      drive(4'b1111, (b >= 3) ? 4'b1111 : 4'b0000, 1'b1);
      checks++; if (so_idx !== 2'd2) begin errors++; $display("FAIL bp_resume_idx beat %0d got %0d want 2", b, so_idx); end
      checks++; if (so_data !== 32'h200 + 32'(b)) begin errors++; $display("FAIL bp_resume_data beat %0d got %h want %h", b, so_data, 32'h200 + 32'(b)); end
      tick();
    end
    drive(4'b1111, 4'b1111, 1'b1);
    checks++; if (so_idx !== 2'd3) begin errors++; $display("FAIL bp_rotate_idx got %0d want 3", so_idx); end
    tick();
  endtask

  task automatic test_flush();
    wt = '{1, 1, 1, 1};
    set_weights();
    flush_pulse(1'b0);
    for (int b = 0; b < 2; b++) begin
      data_d[3] = 32'h300 + 32'(b);
      drive(4'b1000, 4'b0000, 1'b1);
      checks++; if (so_idx !== 2'd3) begin errors++; $display("FAIL flush_pre_idx beat %0d got %0d want 3", b, so_idx); end
      tick();
    end
    data_d[3] = 32'h302;
    flush_d = 1'b1;
    drive(4'b1000, 4'b0000, 1'b1);
    tick();
    flush_d = 1'b0;
    drive(4'b0000, 4'b0000, 1'b1);
    checks++; if (so_req !== 1'b0) begin errors++; $display("FAIL flush_req got %b want 0", so_req); end
    checks++; if (so_gnt !== 4'b0000) begin errors++; $display("FAIL flush_gnt got %b want 0000", so_gnt); end
    tick();
    drive(4'b1111, 4'b1111, 1'b1);
    checks++; if (so_idx !== 2'd0) begin errors++; $display("FAIL flush_next_idx got %0d want 0", so_idx); end
    checks++; if (so_gnt !== 4'b0001) begin errors++; $display("FAIL flush_next_gnt got %b want 0001", so_gnt); end
    tick();
  endtask

  task automatic test_single();
    wt = '{1, 1, 1, 1};
    set_weights();
    flush_pulse(1'b0);
    for (int c = 0; c < 8; c++) begin
      data_d[2] = 32'h2000 + 32'(c);
      drive(4'b0100, 4'b0100, 1'b1);
      checks++;
      if (so_req !== 1'b1 || so_idx !== 2'd2 || so_gnt !== 4'b0100) begin
        errors++; $display("FAIL single cycle %0d got req %b idx %0d gnt %b want 1 2 0100", c, so_req, so_idx, so_gnt);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_weighted();
    test_packet_lock();
    test_backpressure();
    test_flush();
    test_single();
    test_random();
    test_out_reg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
